// File: rtl/syn_div_counter_pkg.sv
// Shared constants for the timing-chain counters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MODE_WRAP / MODE_RELOAD : counter mode selectors for the AUTO_RELOAD parameter
//   WIDTH_MIN / WIDTH_MAX   : legal counter width range
//   width_ok()              : elaboration-time width check helper
package syn_div_counter_pkg;

  localparam bit MODE_WRAP   = 1'b0;
  localparam bit MODE_RELOAD = 1'b1;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 16;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/syn_div_counter.sv
// Programmable divide-by-N / cascadable up-down counter stage with reload register.
// Latency: Q, QB, TCP update one CLK edge after inputs; CO is combinational (zero cycles).
// Backpressure: none; CI acts as count enable, CO feeds the next stage's CI in the same cycle.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset (overrides everything, including WR)
//   CLL    synchronous clear, active low
//   CI     count enable / carry-in
//   UP     1 = count up, 0 = count down
//   LD     load Q from D
//   WR     write D into the reload register
//   D      load / reload data
//   Q, QB  count value and its inverse
//   CO     CI & terminal-count (combinational)
//   TCP    registered one-cycle terminal-count pulse
module syn_div_counter
  import syn_div_counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter bit               AUTO_RELOAD = MODE_RELOAD,
  parameter logic [WIDTH-1:0] RLD_INIT    = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLL,
  input  logic             CI,
  input  logic             UP,
  input  logic             LD,
  input  logic             WR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TCP
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("syn_div_counter: WIDTH out of range");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rld_r;
  logic             tcp_r;
  logic             tc;

  // Terminal count follows the current direction, so a direction change
  // re-targets TC in the same cycle.
  assign tc = UP ? (q_r == '1) : (q_r == '0);
  assign CO = CI & tc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_r   <= '0;
      rld_r <= RLD_INIT;
      tcp_r <= 1'b0;
    end else begin
      // Reload write is independent of the count path; a reload in this same
      // cycle still sees the old rld_r because of non-blocking update.
      if (WR) begin
        rld_r <= D;
      end

      tcp_r <= CI & tc & CLL & ~LD;

      if (!CLL) begin
        q_r <= '0;
      end else if (LD) begin
        q_r <= D;
      end else if (CI && tc && (AUTO_RELOAD == MODE_RELOAD)) begin
        q_r <= rld_r;
      end else if (CI) begin
        q_r <= UP ? (q_r + WIDTH'(1)) : (q_r - WIDTH'(1));
      end
    end
  end

  // Both outputs come from the one register, so QB never skews against Q.
  assign Q   = q_r;
  assign QB  = ~q_r;
  assign TCP = tcp_r;

endmodule

// File: tb/tb_syn_div_counter.sv
// Scoreboard bench for syn_div_counter: 8-bit divider instance plus a 4+4-bit wrap cascade.
// Latency: expectations are checked one CLK edge after the stimulus that produced them.
// Backpressure: none; the monitor pops one expectation per edge per queue.
module tb_syn_div_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Main 8-bit divider-mode instance
  logic       reset, cll, ci, up, ld, wr;
  logic [7:0] d, q, qb;
  logic       co, tcp;

  syn_div_counter #(.WIDTH(8), .AUTO_RELOAD(1'b1), .RLD_INIT(8'h06)) dut (
    .CLK(CLK), .RESET(reset), .CLL(cll), .CI(ci), .UP(up), .LD(ld), .WR(wr),
    .D(d), .Q(q), .QB(qb), .CO(co), .TCP(tcp)
  );

  // Two 4-bit wrap-mode stages chained CO -> CI
  logic       c_reset, c_ld, c_ci;
  logic [7:0] c_d;
  logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_co, lo_tcp, hi_co, hi_tcp;

  syn_div_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0), .RLD_INIT(4'h0)) u_lo (
    .CLK(CLK), .RESET(c_reset), .CLL(1'b1), .CI(c_ci), .UP(1'b1), .LD(c_ld), .WR(1'b0),
    .D(c_d[3:0]), .Q(lo_q), .QB(lo_qb), .CO(lo_co), .TCP(lo_tcp)
  );

  syn_div_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0), .RLD_INIT(4'h0)) u_hi (
    .CLK(CLK), .RESET(c_reset), .CLL(1'b1), .CI(lo_co), .UP(1'b1), .LD(c_ld), .WR(1'b0),
    .D(c_d[7:4]), .Q(hi_q), .QB(hi_qb), .CO(hi_co), .TCP(hi_tcp)
  );

  typedef struct { int q; int tcp; } exp_t;
  typedef struct { int v; int lo_tcp; } cexp_t;
  exp_t  exp_q[$];
  cexp_t cexp_q[$];

  localparam int RLD_RESET = 6;

  int n_checks = 0;
  int n_pass   = 0;
  int tcp_seen = 0;
  int co_seen  = 0;

  // Reference state: main counter value / reload register, cascade combined value
  int m_q = 0, m_rld = 0, c_v = 0;
  bit m_valid = 1'b0, c_valid = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // One cycle on the main instance; the model computes the post-edge state.
  task automatic drive(input bit r, input bit c_ll, input bit c_i, input bit u,
                       input bit l, input bit w, input int dv);
    exp_t e;
    bit   tc;
    @(negedge CLK);
    reset = r; cll = c_ll; ci = c_i; up = u; ld = l; wr = w; d = 8'(dv);
    #1;
    tc = u ? (m_q == 255) : (m_q == 0);
    if (m_valid && !r) begin
      chk("co", int'(co), int'(c_i && tc));
      if (co) co_seen++;
    end
    if (r) begin
      m_q = 0; m_rld = RLD_RESET; e.tcp = 0; m_valid = 1'b1;
    end else begin
      e.tcp = int'(c_i && tc && c_ll && !l);
      if (!c_ll)            m_q = 0;
      else if (l)           m_q = dv % 256;
      else if (c_i && tc)   m_q = m_rld;
      else if (c_i)         m_q = (m_q + (u ? 1 : 255)) % 256;
      if (w) m_rld = dv % 256;
    end
    e.q = m_q;
    exp_q.push_back(e);
  endtask

  // One cycle on the cascade; the model treats it as a single 8-bit up counter.
  task automatic cdrive(input bit r, input bit l, input bit c_i, input int dv);
    cexp_t e;
    @(negedge CLK);
    c_reset = r; c_ld = l; c_ci = c_i; c_d = 8'(dv);
    #1;
    if (c_valid && !r) begin
      chk("lo_co", int'(lo_co), int'(c_i && (c_v % 16 == 15)));
      chk("hi_co", int'(hi_co), int'(c_i && (c_v == 255)));
    end
    if (r) begin
      c_v = 0; e.lo_tcp = 0; c_valid = 1'b1;
    end else begin
      e.lo_tcp = int'(c_i && (c_v % 16 == 15) && !l);
      if (l)        c_v = dv % 256;
      else if (c_i) c_v = (c_v + 1) % 256;
    end
    e.v = c_v;
    cexp_q.push_back(e);
  endtask

  function automatic int pick_d();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 254;
      4: return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: outputs are valid every cycle once stimulus has been issued.
  initial begin
    exp_t  e;
    cexp_t ce;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", int'(q), e.q);
        chk("qb", int'(qb), 255 - e.q);
        chk("tcp", int'(tcp), e.tcp);
        if (tcp) tcp_seen++;
      end
      if (cexp_q.size() > 0) begin
        ce = cexp_q.pop_front();
        chk("casc_value", int'({hi_q, lo_q}), ce.v);
        chk("casc_qb", int'({hi_qb, lo_qb}), 255 - ce.v);
        chk("lo_tcp", int'(lo_tcp), ce.lo_tcp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cll = 1'b1; ci = 1'b0; up = 1'b1; ld = 1'b0; wr = 1'b0; d = '0;
    c_reset = 1'b0; c_ld = 1'b0; c_ci = 1'b0; c_d = '0;

    // Reset dominates CI/LD; then idle hold at 0
    drive(1, 1, 1, 1, 1, 0, 'hA5);
    drive(1, 1, 1, 1, 1, 0, 'hA5);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);

    // Divide-by-5 down counting
    drive(0, 1, 0, 0, 0, 1, 4);
    drive(0, 1, 0, 0, 1, 0, 4);
    co_seen = 0;
    tcp_seen = 0;
    for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge CLK); #2;
    chk("div5_tcp_pulses", tcp_seen, 4);
    chk("div5_co_cycles", co_seen, 4);

    // Clear beats load beats reload at terminal count
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 7);
    drive(0, 1, 0, 0, 1, 0, 7);

    // Reload race: WR in the terminal cycle, old reload value used first
    drive(0, 1, 0, 0, 0, 1, 3);
    drive(0, 1, 0, 0, 1, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 1, 9);
    @(posedge CLK); #2;
    chk("race_old_rld", int'(q), 3);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge CLK); #2;
    chk("race_new_rld", int'(q), 9);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), pick_d());
    end

    // Cascade: 0E -> 0F -> 10 -> 11 -> 12, then a full 8-bit wrap
    cdrive(1, 0, 0, 0);
    cdrive(0, 1, 0, 'h0E);
    for (int i = 0; i < 4; i++) cdrive(0, 0, 1, 0);
    @(posedge CLK); #2;
    chk("casc_0e_plus4", int'({hi_q, lo_q}), 'h12);
    cdrive(0, 1, 0, 'hFD);
    for (int i = 0; i < 5; i++) cdrive(0, 0, 1, 0);
    for (int i = 0; i < 150; i++) begin
      cdrive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 8), pick_d());
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("queues_drained", exp_q.size() + cexp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
